// File: rtl/rate_adapt_ctrl.sv
// Rate-adaptation controller: drains and quiets the line, switches the applied
// speed, lets the adapter settle, and generates the byte-sampling strobe.
module rate_adapt_ctrl #(
  parameter int          QUIET_CYCLES  = 12,
  parameter logic [15:0] DRAIN_TIMEOUT = 16'd50000,
  parameter int          SETTLE_CYCLES = 200,
  parameter logic [1:0]  RESET_SPEED   = 2'b10
) (
  input  logic       i_GClk,
  input  logic       i_Reset,
  input  logic [1:0] i2_SpeedReq,
  input  logic       i_SpeedReqValid,
  output logic       o_SpeedReqAck,
  output logic       o_ReqErr,
  input  logic       i_TxEN,
  input  logic       i_TxER,
  input  logic       i_RxEN,
  input  logic       i_RxER,
  output logic [1:0] o2_Speed,
  output logic       o_SamplingClk,
  output logic       o_TxHold,
  output logic       o_ForceSwitch,
  output logic [1:0] o2_State
);

  localparam int IW = $clog2(QUIET_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      reqSpeed;
  logic [6:0]      divCnt;
  logic [6:0]      divNext;
  logic [6:0]      divTop;
  logic [IW-1:0]   idleCnt;
  logic [15:0]     tmoCnt;
  logic [SW-1:0]   settleCnt;
  logic            firstCyc;
  logic            ackDly;
  logic            activity;
  logic            reqBlock;

  assign o2_State = state;
  assign activity = i_TxEN | i_TxER | i_RxEN | i_RxER;

  // Handshake: the requester holds valid and code stable until it samples the
  // one-cycle ack; valid is not looked at in the ack cycle or the one after it.
  assign reqBlock = o_SpeedReqAck | ackDly;

  assign divTop = (o2_Speed == 2'b00) ? 7'd99 : 7'd9;

  // The strobe is registered alongside the counter so it is high exactly when
  // the visible count is zero; the first post-reset cycle holds the count at 0.
  always_comb begin
    divNext = divCnt + 7'd1;
    if (firstCyc || o2_Speed[1]) divNext = '0;
    else if (divCnt >= divTop)   divNext = '0;
  end

  always_ff @(posedge i_GClk) begin
    if (i_Reset) begin
      state         <= ST_RUN;
      o2_Speed      <= RESET_SPEED;
      reqSpeed      <= RESET_SPEED;
      divCnt        <= '0;
      idleCnt       <= '0;
      tmoCnt        <= '0;
      settleCnt     <= '0;
      firstCyc      <= 1'b1;
      ackDly        <= 1'b0;
      o_SamplingClk <= 1'b0;
      o_SpeedReqAck <= 1'b0;
      o_ReqErr      <= 1'b0;
      o_TxHold      <= 1'b0;
      o_ForceSwitch <= 1'b0;
    end else begin
      firstCyc      <= 1'b0;
      ackDly        <= o_SpeedReqAck;
      o_SpeedReqAck <= 1'b0;
      o_ReqErr      <= 1'b0;
      o_ForceSwitch <= 1'b0;
      divCnt        <= divNext;
      o_SamplingClk <= (divNext == 7'd0);
      case (state)
        ST_RUN: begin
          o_TxHold  <= 1'b0;
          idleCnt   <= '0;
          tmoCnt    <= '0;
          settleCnt <= '0;
          if (i_SpeedReqValid && !reqBlock) begin
            if (i2_SpeedReq == 2'b11) begin
              o_SpeedReqAck <= 1'b1;
              o_ReqErr      <= 1'b1;
            end else if (i2_SpeedReq == o2_Speed) begin
              o_SpeedReqAck <= 1'b1;
            end else begin
              reqSpeed <= i2_SpeedReq;
              o_TxHold <= 1'b1;
              state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          o_TxHold <= 1'b1;
          tmoCnt   <= tmoCnt + 16'd1;
          idleCnt  <= activity ? '0 : idleCnt + 1'b1;
          // Current-cycle activity vetoes the quiet switch, so no frame is cut.
          if (!activity && idleCnt == IW'(QUIET_CYCLES - 1)) begin
            state <= ST_SWITCH;
          end else if (tmoCnt == DRAIN_TIMEOUT - 16'd1) begin
            o_ForceSwitch <= 1'b1;
            state         <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          o2_Speed      <= reqSpeed;
          divCnt        <= '0;
          o_SamplingClk <= 1'b1;
          idleCnt       <= '0;
          tmoCnt        <= '0;
          state         <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settleCnt == SW'(SETTLE_CYCLES - 1)) begin
            settleCnt     <= '0;
            o_SpeedReqAck <= 1'b1;
            o_TxHold      <= 1'b0;
            state         <= ST_RUN;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_adapt_ctrl.sv
// Bench for rate_adapt_ctrl: randomized speed requests against a timeline model
// of acks, forced switches, applied speed, strobe phase and TxHold windows.
module tb_rate_adapt_ctrl;

  localparam logic [1:0] RESET_SPEED = 2'b10;
  localparam int QUIET   = 12;
  localparam int TIMEOUT = 50000;
  localparam int SETTLE  = 200;

  logic       i_GClk = 1'b0;
  logic       i_Reset = 1'b1;
  logic [1:0] i2_SpeedReq = 2'b00;
  logic       i_SpeedReqValid = 1'b0;
  logic       i_TxEN = 1'b0, i_TxER = 1'b0, i_RxEN = 1'b0, i_RxER = 1'b0;
  logic       o_SpeedReqAck, o_ReqErr, o_SamplingClk, o_TxHold, o_ForceSwitch;
  logic [1:0] o2_Speed, o2_State;

  rate_adapt_ctrl dut (
    .i_GClk          (i_GClk),
    .i_Reset         (i_Reset),
    .i2_SpeedReq     (i2_SpeedReq),
    .i_SpeedReqValid (i_SpeedReqValid),
    .o_SpeedReqAck   (o_SpeedReqAck),
    .o_ReqErr        (o_ReqErr),
    .i_TxEN          (i_TxEN),
    .i_TxER          (i_TxER),
    .i_RxEN          (i_RxEN),
    .i_RxER          (i_RxER),
    .o2_Speed        (o2_Speed),
    .o_SamplingClk   (o_SamplingClk),
    .o_TxHold        (o_TxHold),
    .o_ForceSwitch   (o_ForceSwitch),
    .o2_State        (o2_State)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #4 i_GClk = ~i_GClk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge i_GClk) begin
    cyc      <= cyc + 1;
    rst_seen <= i_Reset;
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [34:0] exp_q[$];     // {cycle, kind (0 ack, 1 force, 2 stray err), err}
  logic [63:0] hold_q[$];    // {first cycle, last cycle} with TxHold high
  logic [33:0] anchor_q[$];  // {cycle, speed} where a new speed becomes visible
  logic [1:0]  model_speed = RESET_SPEED;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_event(input logic [34:0] obs);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL event at cycle %0d: got %0h, expected none", cyc, obs);
    end else begin
      check("event", 64'(obs), 64'(exp_q.pop_front()));
    end
  endtask

  // ---------------- monitor ----------------
  logic       started = 1'b0;
  logic       prev_rst = 1'b0;
  logic [1:0] exp_speed = RESET_SPEED;
  int         anchor = 0;
  int         period;
  logic       exp_strobe;
  logic       exp_hold;

  always @(negedge i_GClk) begin
    if (rst_seen) begin
      started   = 1'b1;
      prev_rst  = 1'b1;
      exp_speed = RESET_SPEED;
      check("rst_speed",  64'(o2_Speed), 64'(RESET_SPEED));
      check("rst_strobe", 64'(o_SamplingClk), 64'd0);
      check("rst_ack",    64'(o_SpeedReqAck), 64'd0);
      check("rst_err",    64'(o_ReqErr), 64'd0);
      check("rst_hold",   64'(o_TxHold), 64'd0);
      check("rst_force",  64'(o_ForceSwitch), 64'd0);
      check("rst_state",  64'(o2_State), 64'd0);
    end else if (started) begin
      if (prev_rst) begin
        anchor   = cyc;
        prev_rst = 1'b0;
      end
      if (anchor_q.size() > 0 && int'(anchor_q[0][33:2]) == cyc) begin
        exp_speed = anchor_q[0][1:0];
        anchor    = cyc;
        void'(anchor_q.pop_front());
      end
      check("speed", 64'(o2_Speed), 64'(exp_speed));
      period     = (exp_speed == 2'b00) ? 100 : 10;
      exp_strobe = (exp_speed == 2'b10) ? 1'b1 : (((cyc - anchor) % period) == 0);
      check("strobe", 64'(o_SamplingClk), 64'(exp_strobe));
      exp_hold = (hold_q.size() > 0 && cyc >= int'(hold_q[0][63:32]) && cyc <= int'(hold_q[0][31:0]));
      check("txhold", 64'(o_TxHold), 64'(exp_hold));
      if (hold_q.size() > 0 && cyc == int'(hold_q[0][31:0])) void'(hold_q.pop_front());
      if (o_ForceSwitch) check_event({32'(cyc), 2'd1, 1'b0});
      if (o_SpeedReqAck) check_event({32'(cyc), 2'd0, o_ReqErr});
      else if (o_ReqErr) check_event({32'(cyc), 2'd2, 1'b1});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_act(input bit on, input bit rx_only);
    logic [3:0] a;
    a = 4'd0;
    if (on) a = rx_only ? 4'b0010 : 4'($urandom_range(1, 15));
    {i_TxEN, i_TxER, i_RxEN, i_RxER} = a;
  endtask

  task automatic do_reset(input int n);
    i_Reset = 1'b1;
    i_SpeedReqValid = 1'b0;
    drive_act(1'b0, 1'b0);
    @(posedge i_GClk); #1;
    exp_q.delete();
    hold_q.delete();
    anchor_q.delete();
    model_speed = RESET_SPEED;
    repeat (n) begin
      @(posedge i_GClk); #1;
    end
    i_Reset = 1'b0;
  endtask

  // mode: 0 random bursts with idle gaps, 1 never idle, 2 Rx busy 40 cycles, 3 idle.
  // abort_at > 0 returns abort_at cycles into SETTLE with valid still high.
  task automatic do_request(input logic [1:0] code, input int mode, input int abort_at, input int extra);
    int p, q, k, x, j, jsw, run, n;
    bit forced, on;
    bit seq[$];
    @(posedge i_GClk); #1;
    p = cyc;
    i2_SpeedReq = code;
    i_SpeedReqValid = 1'b1;
    drive_act(1'($urandom_range(0, 1)), 1'b0);
    if (code == 2'b11 || code == model_speed) begin
      k = p + 1;
      exp_q.push_back({32'(k), 2'd0, code == 2'b11});
      while (cyc < k + extra) begin
        @(posedge i_GClk); #1;
        drive_act(1'($urandom_range(0, 1)), 1'b0);
      end
      i_SpeedReqValid = 1'b0;
      return;
    end
    if (mode == 0) begin
      for (int s = 0; s < 3; s++) begin
        repeat ($urandom_range(1, 5)) seq.push_back(1'b1);
        n = ($urandom_range(0, 1) != 0) ? QUIET - 1 : $urandom_range(0, 8);
        repeat (n) seq.push_back(1'b0);
      end
      seq.push_back(1'b1);
    end else if (mode == 2) begin
      repeat (40) seq.push_back(1'b1);
    end
    // Switch point: first run of QUIET idle DRAIN cycles, else the timeout.
    run = 0;
    forced = 1'b0;
    for (j = 0; ; j++) begin
      on = (mode == 1) ? 1'b1 : (j < seq.size() ? seq[j] : 1'b0);
      run = on ? 0 : run + 1;
      if (run == QUIET) break;
      if (j == TIMEOUT - 1) begin
        forced = 1'b1;
        break;
      end
    end
    jsw = j;
    q = p + 2 + jsw;
    if (forced) exp_q.push_back({32'(q), 2'd1, 1'b0});
    anchor_q.push_back({32'(q + 1), code});
    x = q + 1 + abort_at;
    k = q + 1 + SETTLE;
    if (abort_at > 0) hold_q.push_back({32'(p + 1), 32'(x)});
    else begin
      exp_q.push_back({32'(k), 2'd0, 1'b0});
      hold_q.push_back({32'(p + 1), 32'(k - 1)});
    end
    forever begin
      j = cyc - p - 1;
      if (j >= 0 && j <= jsw) begin
        on = (mode == 1) ? 1'b1 : (j < seq.size() ? seq[j] : 1'b0);
        drive_act(on, mode == 2);
      end else begin
        drive_act(1'($urandom_range(0, 1)), 1'b0);
      end
      if (cyc > p + 1 && $urandom_range(0, 3) == 0) i2_SpeedReq = 2'($urandom_range(0, 3));
      if (abort_at > 0 && cyc == x) break;
      if (abort_at == 0 && cyc == k + extra) begin
        i_SpeedReqValid = 1'b0;
        break;
      end
      @(posedge i_GClk); #1;
    end
    model_speed = code;
  endtask

  // ---------------- test sequence ----------------
  logic [1:0] rc;
  initial begin
    do_reset(5);
    repeat (13) @(posedge i_GClk);
    #1;
    do_request(2'b11, 0, 0, 1);              // reserved code
    do_request(model_speed, 0, 0, 2);        // already at requested speed
    do_request(2'b01, 3, 0, 1);              // 1000M -> 100M, line idle
    do_request(2'b00, 2, 0, 1);              // 100M -> 10M behind 40 Rx cycles
    for (int i = 0; i < 6; i++) begin
      rc = 2'($urandom_range(0, 3));
      do_request(rc, ($urandom_range(0, 1) != 0) ? 0 : 3, 0, $urandom_range(1, 2));
    end
    rc = (model_speed == 2'b00) ? 2'b01 : 2'b00;
    do_request(rc, 0, $urandom_range(1, SETTLE - 1), 1);
    do_reset(4);
    do_request(2'b00, 1, 0, 2);              // timeout-forced switch, valid held longer
    do_request(2'b10, 3, 0, 1);
    repeat (120) @(posedge i_GClk);
    #1;
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event: got none, expected %0h", exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rate_adapt_ctrl.md
RATE_ADAPT_CTRL -- requirements
Module: rate_adapt_ctrl

Interface
REQ-001 Parameter: QUIET_CYCLES, 12, consecutive idle cycles (Tx and Rx) required before a speed switch.
REQ-002 Parameter: DRAIN_TIMEOUT, 16'd50000, max DRAIN cycles before a forced switch.
REQ-003 Parameter: SETTLE_CYCLES, 200, cycles held in SETTLE after a switch.
REQ-004 Parameter: RESET_SPEED, 2'b10, speed code loaded on reset.
REQ-005 Port: i_GClk  in  1  125 MHz clock; the only clock; all ports synchronous to it.
REQ-006 Port: i_Reset  in  1  reset, synchronous, active-high.
REQ-007 Port: i2_SpeedReq  in  2  requested speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = reserved.
REQ-008 Port: i_SpeedReqValid  in  1  request valid; held with i2_SpeedReq stable until ack.
REQ-009 Port: o_SpeedReqAck  out  1  one-cycle request acknowledge.
REQ-010 Port: o_ReqErr  out  1  one-cycle pulse, coincident with ack, for a reserved code.
REQ-011 Port: i_TxEN, i_TxER, i_RxEN, i_RxER  in  1 each  PHY-side frame activity.
REQ-012 Port: o2_Speed  out  2  current speed applied to the rate adapter.
REQ-013 Port: o_SamplingClk  out  1  byte-sampling strobe for the rate adapter.
REQ-014 Port: o_TxHold  out  1  level; MAC shall not start a new frame while high.
REQ-015 Port: o_ForceSwitch  out  1  one-cycle pulse when a switch is forced by timeout.

Function
REQ-016 All outputs shall be registered.
REQ-017 Activity shall be defined as i_TxEN | i_TxER | i_RxEN | i_RxER.
REQ-018 Strobe generator: a 7-bit divider counter shall run 0..N-1, then wrap to 0.
- N = 10 at 100M; N = 100 at 10M.
- o_SamplingClk shall be high only when the counter equals 0.
- At 1000M, o_SamplingClk shall be constantly 1 and the counter shall be held at 0.
REQ-019 The FSM shall have the states RUN, DRAIN, SWITCH and SETTLE.
REQ-020 RUN: o_TxHold = 0. On i_SpeedReqValid:
- reserved code: ack + o_ReqErr in the next cycle; stay in RUN.
- code equal to o2_Speed: ack in the next cycle; stay in RUN; no change.
- otherwise: latch the code and go to DRAIN.
REQ-021 DRAIN: o_TxHold = 1.
- The idle counter shall clear on any active cycle and otherwise increment.
- Reaching QUIET_CYCLES -> SWITCH.
- A frame in progress shall never be truncated by a quiet-driven switch.
REQ-022 DRAIN timeout: the timeout counter shall count every DRAIN cycle.
- On reaching DRAIN_TIMEOUT: pulse o_ForceSwitch and go to SWITCH regardless of activity.
REQ-023 SWITCH (exactly one cycle): o2_Speed shall take the latched code; the divider counter shall clear to 0; go to SETTLE.
- The first strobe at the new speed shall occur in the cycle after SWITCH.
REQ-024 SETTLE: o_TxHold = 1 for SETTLE_CYCLES cycles.
- Then: o_SpeedReqAck pulses for one cycle and the FSM returns to RUN, with o_TxHold = 0 in the same cycle.
REQ-025 The block shall ignore i_SpeedReqValid outside RUN, in the ack cycle, and in the cycle after the ack.
REQ-026 The requester shall deassert valid in the cycle after sampling ack.
REQ-027 Changes to i2_SpeedReq while a request is in progress shall be ignored; the latched code governs.
REQ-028 Activity in the same cycle that the idle count completes shall block the switch: that cycle's idle test uses its own activity inputs.

Reset
REQ-029 While i_Reset is high:
- FSM = RUN; o2_Speed = RESET_SPEED.
- Divider, idle and timeout counters = 0.
- o_SamplingClk, o_SpeedReqAck, o_ReqErr, o_TxHold, o_ForceSwitch = 0.
REQ-030 Reset mid-request shall abandon the request with no ack; the latched code shall be discarded.
REQ-031 In the first cycle after reset release, o_SamplingClk shall be 1 at every speed.
- At 100M/10M it shall then repeat every N cycles.

Verification
REQ-032 Reset with RESET_SPEED = 2'b10, then request 01 with the line idle:
- 12 idle cycles, then SWITCH; o2_Speed = 01.
- Strobe every 10 cycles; ack 200 cycles after SWITCH; o_TxHold high DRAIN through SETTLE.
REQ-033 At 100M, request 00 while Rx is active for 40 cycles:
- o2_Speed shall be unchanged until 12 idle cycles follow Rx end.
- After the switch, strobe period = 100.
REQ-034 Request 00 with activity never dropping:
- o_ForceSwitch pulses after 50000 DRAIN cycles; o2_Speed = 00 in the next cycle.
REQ-035 Request 11, then a request equal to the current speed:
- Each is acked in the next cycle; o_ReqErr = 1 only for 11; o2_Speed unchanged; no DRAIN entered.
REQ-036 Assert i_Reset during SETTLE:
- No ack; o2_Speed = RESET_SPEED.
- Next request accepted normally; valid held through an ack is not double-acked.
